player_controller: RTL and testbench

Parametrised successor to the single-player movement/attack FSM. It converts per-frame controller samples into a grid position, a facing, an animation sprite and a timed sword hit box. Generalisations: parametrised grid bounds, spawn point and attack/cooldown/auto-repeat durations. New behaviour: post-attack cooldown, held-direction auto-repeat, off-grid sword suppression, synchronous respawn and freeze. Sits between the input controller and the Game State Controller, which owns collisions and lives.

---
 rtl/player_pkg.sv | 55 +++++
 rtl/player_controller_if.sv | 30 +++
 rtl/sprite_animator.sv | 54 +++++
 rtl/player_controller.sv | 212 +++++++++++++++++++++
 tb/tb_player_controller.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/player_pkg.sv
// Shared codes for the player controller: directions, states, sprite/sword encodings
// and the controller input bit map with its direction-priority decoder.
package player_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MOVE     = 2'b01,
    ATTACK   = 2'b10,
    COOLDOWN = 2'b11
  } state_e;

  localparam logic [3:0] SPRITE_IDLE_A = 4'b0011;
  localparam logic [3:0] SPRITE_IDLE_B = 4'b0010;
  localparam logic [3:0] SPRITE_ATTACK = 4'b0100;

  localparam logic [3:0] SWORD_VISIBLE = 4'b0001;
  localparam logic [3:0] SWORD_HIDDEN  = 4'b1111;

  localparam logic [1:0] ORIENT_RIGHT = 2'b01;
  localparam logic [1:0] ORIENT_LEFT  = 2'b11;

  localparam int BIT_ATTACK = 9;
  localparam int BIT_RIGHT  = 8;
  localparam int BIT_LEFT   = 7;
  localparam int BIT_DOWN   = 6;
  localparam int BIT_UP     = 5;

  typedef struct packed {
    logic any;
    dir_e dir;
  } press_t;

  // Right beats left beats down beats up when several are held.
  function automatic press_t decode_press(input logic [9:0] d);
    press_t p;
    p.any = 1'b1;
    if (d[BIT_RIGHT])      p.dir = DIR_RIGHT;
    else if (d[BIT_LEFT])  p.dir = DIR_LEFT;
    else if (d[BIT_DOWN])  p.dir = DIR_DOWN;
    else if (d[BIT_UP])    p.dir = DIR_UP;
    else begin
      p.any = 1'b0;
      p.dir = DIR_UP;
    end
    return p;
  endfunction

endpackage

// File: rtl/player_controller_if.sv
// Frame-rate controls into the player controller and its registered outputs.
interface player_controller_if #(
  parameter int XW = 4,
  parameter int YW = 4
);
  logic              trigger;
  logic [9:0]        input_data;
  logic              respawn;
  logic              freeze;
  logic [XW+YW-1:0]  player_pos;
  logic [1:0]        player_orientation;
  logic [1:0]        player_direction;
  logic [3:0]        player_sprite;
  logic [XW+YW-1:0]  sword_position;
  logic [3:0]        sword_visible;
  logic [1:0]        sword_orientation;
  logic              attack_active;

  modport master (
    output trigger, input_data, respawn, freeze,
    input  player_pos, player_orientation, player_direction, player_sprite,
           sword_position, sword_visible, sword_orientation, attack_active
  );

  modport slave (
    input  trigger, input_data, respawn, freeze,
    output player_pos, player_orientation, player_direction, player_sprite,
           sword_position, sword_visible, sword_orientation, attack_active
  );
endinterface

// File: rtl/sprite_animator.sv
// Idle animation phase counter; attack_active is the controller's next-cycle attack
// flag so the sprite register switches on the same edge as attack_active itself.
module sprite_animator
  import player_pkg::*;
#(
  parameter int ANIM_PERIOD = 21,
  parameter int ANIM_TOGGLE = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic       attack_active,
  output logic [3:0] player_sprite
);

  localparam int AW = $clog2(ANIM_PERIOD);
  localparam logic [AW-1:0] CNT_LAST = AW'(ANIM_PERIOD - 1);
  localparam logic [AW-1:0] CNT_TOG  = AW'(ANIM_TOGGLE);
  localparam logic [AW-1:0] CNT_ONE  = AW'(1);

  logic [AW-1:0] anim_cnt_q, anim_cnt_d;
  logic [3:0]    phase_q, phase_d;
  logic [3:0]    sprite_q, sprite_d;

  always_comb begin
    anim_cnt_d = anim_cnt_q;
    phase_d    = phase_q;
    if (trigger) begin
      if (anim_cnt_q == CNT_LAST) begin
        anim_cnt_d = '0;
        phase_d    = SPRITE_IDLE_A;
      end else begin
        anim_cnt_d = anim_cnt_q + CNT_ONE;
        if (anim_cnt_q == CNT_TOG) phase_d = SPRITE_IDLE_B;
      end
    end
    sprite_d = attack_active ? SPRITE_ATTACK : phase_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anim_cnt_q <= '0;
      phase_q    <= SPRITE_IDLE_A;
      sprite_q   <= SPRITE_IDLE_A;
    end else begin
      anim_cnt_q <= anim_cnt_d;
      phase_q    <= phase_d;
      sprite_q   <= sprite_d;
    end
  end

  assign player_sprite = sprite_q;

endmodule

// File: rtl/player_controller.sv
// Per-frame player movement/attack controller: grid position, facing, timed sword
// hit box with cooldown, held-direction auto-repeat, respawn and freeze.
module player_controller
  import player_pkg::*;
#(
  parameter int XW              = 4,
  parameter int YW              = 4,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 15,
  parameter int Y_MIN           = 2,
  parameter int Y_MAX           = 11,
  parameter int SPAWN_X         = 1,
  parameter int SPAWN_Y         = 3,
  parameter int ATTACK_FRAMES   = 5,
  parameter int COOLDOWN_FRAMES = 3,
  parameter int REPEAT_FRAMES   = 4,
  parameter int ANIM_PERIOD     = 21,
  parameter int ANIM_TOGGLE     = 7
) (
  input  logic clk,
  input  logic reset,
  player_controller_if.slave bus
);

  localparam int CNT_W = 8;
  localparam int XS    = X_MAX - X_MIN;
  localparam int YS    = Y_MAX - Y_MIN;
  localparam logic [XW:0]      X_LO   = X_MIN[XW:0];
  localparam logic [YW:0]      Y_LO   = Y_MIN[YW:0];
  localparam logic [XW:0]      X_SPAN = XS[XW:0];
  localparam logic [YW:0]      Y_SPAN = YS[YW:0];
  localparam logic [XW:0]      X_INC  = {{XW{1'b0}}, 1'b1};
  localparam logic [YW:0]      Y_INC  = {{YW{1'b0}}, 1'b1};
  localparam logic [XW-1:0]    SPX    = SPAWN_X[XW-1:0];
  localparam logic [YW-1:0]    SPY    = SPAWN_Y[YW-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ATTACK_LOAD = CNT_W'(ATTACK_FRAMES);
  localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_FRAMES);

  state_e              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  dir_e                dir_q, dir_d;
  logic [1:0]          orient_q, orient_d;
  logic [XW+YW-1:0]    sword_pos_q, sword_pos_d;
  logic [3:0]          sword_vis_q, sword_vis_d;
  dir_e                sword_ori_q, sword_ori_d;
  logic                attack_q, attack_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  press_t              press;
  dir_e                act_dir;
  logic                frame, do_turn, do_step, nb_ok;
  logic [XW:0]         nx;
  logic [YW:0]         ny;

  // Neighbour cell in the acting direction, one spare bit per axis so that
  // stepping off either edge lands outside the unsigned window check.
  always_comb begin
    press   = decode_press(bus.input_data);
    act_dir = press.any ? press.dir : dir_q;
    nx      = {1'b0, x_q};
    ny      = {1'b0, y_q};
    case (act_dir)
      DIR_UP:    ny = ny - Y_INC;
      DIR_RIGHT: nx = nx + X_INC;
      DIR_DOWN:  ny = ny + Y_INC;
      default:   nx = nx - X_INC;
    endcase
    nb_ok = ((nx - X_LO) <= X_SPAN) && ((ny - Y_LO) <= Y_SPAN);
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_d       = dir_q;
    orient_d    = orient_q;
    sword_pos_d = sword_pos_q;
    sword_vis_d = sword_vis_q;
    sword_ori_d = sword_ori_q;
    cnt_d       = cnt_q;
    do_turn     = 1'b0;
    do_step     = 1'b0;
    frame       = bus.trigger && !bus.freeze;

    if (bus.respawn) begin
      state_d     = IDLE;
      x_d         = SPX;
      y_d         = SPY;
      sword_vis_d = SWORD_HIDDEN;
      cnt_d       = '0;
    end else if (frame) begin
      case (state_q)
        IDLE: begin
          if (bus.input_data[BIT_ATTACK]) begin
            do_turn     = 1'b1;
            sword_ori_d = act_dir;
            if (nb_ok) begin
              sword_pos_d = {nx[XW-1:0], ny[YW-1:0]};
              sword_vis_d = SWORD_VISIBLE;
            end
            state_d = ATTACK;
            cnt_d   = ATTACK_LOAD;
          end else if (press.any) begin
            do_turn = 1'b1;
            do_step = 1'b1;
            state_d = MOVE;
            cnt_d   = REPEAT_LOAD;
          end
        end
        MOVE: begin
          if (!press.any) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q <= CNT_ONE) begin
            do_turn = 1'b1;
            do_step = 1'b1;
            cnt_d   = REPEAT_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ATTACK: begin
          if (cnt_q <= CNT_ONE) begin
            sword_vis_d = SWORD_HIDDEN;
            if (COOLDOWN_FRAMES == 0) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = COOLDOWN;
              cnt_d   = COOL_LOAD;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          // Cooldown: steps allowed every frame a direction is held, attacks dropped.
          if (press.any) begin
            do_turn = 1'b1;
            do_step = 1'b1;
          end
          if (cnt_q <= CNT_ONE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      endcase
    end

    if (do_turn) begin
      dir_d = act_dir;
      if (act_dir == DIR_RIGHT)     orient_d = ORIENT_RIGHT;
      else if (act_dir == DIR_LEFT) orient_d = ORIENT_LEFT;
    end
    if (do_step && nb_ok) begin
      x_d = nx[XW-1:0];
      y_d = ny[YW-1:0];
    end
    attack_d = (state_d == ATTACK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      x_q         <= SPX;
      y_q         <= SPY;
      dir_q       <= DIR_RIGHT;
      orient_q    <= ORIENT_RIGHT;
      sword_pos_q <= '0;
      sword_vis_q <= SWORD_HIDDEN;
      sword_ori_q <= DIR_UP;
      attack_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      orient_q    <= orient_d;
      sword_pos_q <= sword_pos_d;
      sword_vis_q <= sword_vis_d;
      sword_ori_q <= sword_ori_d;
      attack_q    <= attack_d;
      cnt_q       <= cnt_d;
    end
  end

  sprite_animator #(
    .ANIM_PERIOD (ANIM_PERIOD),
    .ANIM_TOGGLE (ANIM_TOGGLE)
  ) u_sprite (
    .clk           (clk),
    .reset         (reset),
    .trigger       (bus.trigger),
    .attack_active (attack_d),
    .player_sprite (bus.player_sprite)
  );

  assign bus.player_pos         = {x_q, y_q};
  assign bus.player_orientation = orient_q;
  assign bus.player_direction   = dir_q;
  assign bus.sword_position     = sword_pos_q;
  assign bus.sword_visible      = sword_vis_q;
  assign bus.sword_orientation  = sword_ori_q;
  assign bus.attack_active      = attack_q;

endmodule

// File: tb/tb_player_controller.sv
// Bench for player_controller: directed scenarios plus randomized frames, all checked
// against a frame-deadline reference model of the player's behaviour.
module tb_player_controller;
  localparam int XMIN = 0, XMAX = 15, YMIN = 2, YMAX = 11, SPX = 1, SPY = 3;
  localparam int AF = 5, CF = 3, RF = 4, AP = 21, AT = 7;
  localparam int M_IDLE = 0, M_MOVE = 1, M_ATT = 2, M_COOL = 3;
  localparam logic [9:0] K_R = 10'h100, K_L = 10'h080, K_D = 10'h040, K_U = 10'h020;
  localparam logic [9:0] K_A = 10'h200, K_0 = 10'h000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  player_controller_if #(.XW(4), .YW(4)) bus ();

  player_controller #(
    .XW(4), .YW(4), .X_MIN(XMIN), .X_MAX(XMAX), .Y_MIN(YMIN), .Y_MAX(YMAX),
    .SPAWN_X(SPX), .SPAWN_Y(SPY), .ATTACK_FRAMES(AF), .COOLDOWN_FRAMES(CF),
    .REPEAT_FRAMES(RF), .ANIM_PERIOD(AP), .ANIM_TOGGLE(AT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position, facing, mode and absolute frame deadlines.
  int mx, my, mdir, mori, mode, af, t_next, t_end, trigs;
  int s_on, sx, sy, sori;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] idle_phase(input int n);
    int c;
    if (n == 0) return 4'b0011;
    c = (n - 1) % AP;
    return (c >= AT && c <= AP - 2) ? 4'b0010 : 4'b0011;
  endfunction

  function automatic int dxf(input int d);
    return (d == 1) ? 1 : (d == 3) ? -1 : 0;
  endfunction

  function automatic int dyf(input int d);
    return (d == 2) ? 1 : (d == 0) ? -1 : 0;
  endfunction

  function automatic bit on_grid(input int x, input int y);
    return x >= XMIN && x <= XMAX && y >= YMIN && y <= YMAX;
  endfunction

  task automatic model_reset();
    mx = SPX; my = SPY; mdir = 1; mori = 1; mode = M_IDLE;
    af = 0; t_next = 0; t_end = 0; trigs = 0;
    s_on = 0; sx = 0; sy = 0; sori = 0;
  endtask

  task automatic face(input int d);
    mdir = d;
    if (d == 1) mori = 1;
    if (d == 3) mori = 3;
  endtask

  task automatic walk(input int d);
    face(d);
    if (on_grid(mx + dxf(d), my + dyf(d))) begin
      mx = mx + dxf(d);
      my = my + dyf(d);
    end
  endtask

  task automatic model(input bit trig, input logic [9:0] data, input bit resp, input bit frz);
    bit any;
    int pd, d, tx, ty;
    any = 1'b1;
    if (data[8])      pd = 1;
    else if (data[7]) pd = 3;
    else if (data[6]) pd = 2;
    else if (data[5]) pd = 0;
    else begin any = 1'b0; pd = 0; end
    if (resp) begin
      mx = SPX; my = SPY; mode = M_IDLE; s_on = 0;
    end else if (trig && !frz) begin
      af++;
      case (mode)
        M_IDLE: begin
          if (data[9]) begin
            d = any ? pd : mdir;
            tx = mx + dxf(d);
            ty = my + dyf(d);
            face(d);
            sori = d;
            if (on_grid(tx, ty)) begin sx = tx; sy = ty; s_on = 1; end
            mode = M_ATT;
            t_end = af + AF;
          end else if (any) begin
            walk(pd);
            mode = M_MOVE;
            t_next = af + RF;
          end
        end
        M_MOVE: begin
          if (!any) mode = M_IDLE;
          else if (af == t_next) begin walk(pd); t_next = af + RF; end
        end
        M_ATT: begin
          if (af == t_end) begin
            s_on = 0;
            if (CF > 0) begin mode = M_COOL; t_end = af + CF; end
            else mode = M_IDLE;
          end
        end
        default: begin
          if (any) walk(pd);
          if (af == t_end) mode = M_IDLE;
        end
      endcase
    end
    if (trig) trigs++;
  endtask

  task automatic check_all();
    chk("pos",       32'(bus.player_pos),         32'((mx << 4) | my));
    chk("dir",       32'(bus.player_direction),   32'(mdir));
    chk("orient",    32'(bus.player_orientation), 32'(mori));
    chk("sprite",    32'(bus.player_sprite),      32'((mode == M_ATT) ? 4'b0100 : idle_phase(trigs)));
    chk("sword_vis", 32'(bus.sword_visible),      32'(s_on ? 4'b0001 : 4'b1111));
    chk("sword_pos", 32'(bus.sword_position),     32'((sx << 4) | sy));
    chk("sword_ori", 32'(bus.sword_orientation),  32'(sori));
    chk("attack",    32'(bus.attack_active),      32'(mode == M_ATT));
  endtask

  task automatic step(input bit trig, input logic [9:0] data, input bit resp, input bit frz);
    bus.trigger    = trig;
    bus.input_data = data;
    bus.respawn    = resp;
    bus.freeze     = frz;
    model(trig, data, resp, frz);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic frames(input logic [9:0] data, input int n);
    for (int i = 0; i < n; i++) step(1'b1, data, 1'b0, 1'b0);
  endtask

  initial begin
    int vis_len;
    reset          = 1'b0;
    bus.trigger    = 1'b0;
    bus.input_data = '0;
    bus.respawn    = 1'b0;
    bus.freeze     = 1'b0;
    model_reset();
    #12;
    check_all();
    #1 reset = 1'b1;

    // Held right: steps at frames 0, 4 and 8.
    frames(K_R, 9);
    chk("walk_x", 32'(bus.player_pos[7:4]), 32'd4);

    // Into the top-left corner, then push against both edges.
    frames(K_0, 1);
    frames(K_U, 1);
    frames(K_0, 1);
    frames(K_L, 17);
    frames(K_0, 1);
    frames(K_L | K_U, 1);
    chk("corner_pos", 32'(bus.player_pos), 32'h02);
    chk("corner_dir", 32'(bus.player_direction), 32'd3);
    frames(K_0, 1);
    frames(K_A, 1);
    chk("offgrid_vis", 32'(bus.sword_visible), 32'hf);
    chk("offgrid_atk", 32'(bus.attack_active), 32'd1);
    frames(K_0, 8);

    // Walk to (5,5), attack right, probe the cooldown window.
    step(1'b0, K_0, 1'b1, 1'b0);
    frames(K_R, 13);
    frames(K_0, 1);
    frames(K_D, 5);
    frames(K_0, 1);
    frames(K_A | K_R, 1);
    chk("atk_pos", 32'(bus.sword_position), 32'h65);
    vis_len = (bus.sword_visible == 4'b0001) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      frames(K_0, 1);
      if (bus.sword_visible == 4'b0001) vis_len++;
    end
    chk("atk_len", 32'(vis_len), 32'd5);
    for (int i = 0; i < 3; i++) begin
      frames(K_A, 1);
      chk("cool_block", 32'(bus.attack_active), 32'd0);
    end
    frames(K_A, 1);
    chk("cool_done", 32'(bus.attack_active), 32'd1);
    frames(K_0, 8);

    // Attack downward.
    frames(K_A | K_D, 1);
    chk("down_pos", 32'(bus.sword_position), 32'h56);
    chk("down_ori", 32'(bus.sword_orientation), 32'd2);
    chk("down_dir", 32'(bus.player_direction), 32'd2);
    frames(K_0, 2);

    // Respawn beats a coincident trigger mid-attack.
    step(1'b1, K_0, 1'b1, 1'b0);
    chk("resp_pos", 32'(bus.player_pos), 32'h13);
    chk("resp_vis", 32'(bus.sword_visible), 32'hf);
    chk("resp_atk", 32'(bus.attack_active), 32'd0);

    // Asynchronous reset mid-move, no clock edge needed.
    frames(K_R, 3);
    bus.trigger = 1'b0;
    bus.input_data = '0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("areset_pos", 32'(bus.player_pos), 32'h13);
    #2 reset = 1'b1;

    // Frozen with right held: static, animation still toggles at frame 7.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, K_R, 1'b0, 1'b1);
      chk("frz_pos", 32'(bus.player_pos), 32'h13);
      if (i == 6) chk("frz_spr6", 32'(bus.player_sprite), 32'h3);
      if (i == 7) chk("frz_spr7", 32'(bus.player_sprite), 32'h2);
    end

    // Randomized frames.
    for (int i = 0; i < 3000; i++) begin
      logic [9:0] d;
      d = 10'($urandom);
      d[9] = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 2) != 0, d, $urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
